// File: rtl/branch_pkg.sv
// Shared branch-type codes, controller state encoding and stall-depth constants
// for the ID-stage branch resolution logic.
package branch_pkg;

    localparam logic [2:0] BR_NONE = 3'd0;
    localparam logic [2:0] BR_BEQ  = 3'd1;
    localparam logic [2:0] BR_BNE  = 3'd2;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_STALL = 1'b1
    } state_t;

    // Cycles the branch must wait before its operands can be compared.
    localparam logic [1:0] NEED_NONE     = 2'd0;
    localparam logic [1:0] NEED_EX_ALU   = 2'd1;
    localparam logic [1:0] NEED_MEM_LOAD = 2'd1;
    localparam logic [1:0] NEED_EX_LOAD  = 2'd2;

    function automatic logic [1:0] max_need(input logic [1:0] a, input logic [1:0] b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/branch_hazard_detect.sv
// Combinational hazard check for the two branch source operands against the
// EX and MEM destinations: stall depth and MEM-stage forwarding selects.
module branch_hazard_detect
    import branch_pkg::*;
#(
    parameter int REG_W = 5
) (
    input  logic [REG_W-1:0] i_rs,
    input  logic [REG_W-1:0] i_rt,
    input  logic             i_ex_reg_write,
    input  logic             i_ex_mem_read,
    input  logic [REG_W-1:0] i_ex_write_reg,
    input  logic             i_mem_reg_write,
    input  logic             i_mem_mem_read,
    input  logic [REG_W-1:0] i_mem_write_reg,
    output logic [1:0]       o_need,
    output logic             o_fwd_a,
    output logic             o_fwd_b
);

    logic       w_rs_ex, w_rt_ex, w_rs_mem, w_rt_mem;
    logic [1:0] w_need_rs, w_need_rt;

    // Register 0 is hardwired to zero, so it can never carry a hazard.
    assign w_rs_ex  = (i_rs != '0) && (i_rs == i_ex_write_reg)  && (i_ex_reg_write  || i_ex_mem_read);
    assign w_rt_ex  = (i_rt != '0) && (i_rt == i_ex_write_reg)  && (i_ex_reg_write  || i_ex_mem_read);
    assign w_rs_mem = (i_rs != '0) && (i_rs == i_mem_write_reg) && (i_mem_reg_write || i_mem_mem_read);
    assign w_rt_mem = (i_rt != '0) && (i_rt == i_mem_write_reg) && (i_mem_reg_write || i_mem_mem_read);

    assign w_need_rs = w_rs_ex  ? (i_ex_mem_read ? NEED_EX_LOAD : NEED_EX_ALU) :
                       (w_rs_mem && i_mem_mem_read) ? NEED_MEM_LOAD : NEED_NONE;
    assign w_need_rt = w_rt_ex  ? (i_ex_mem_read ? NEED_EX_LOAD : NEED_EX_ALU) :
                       (w_rt_mem && i_mem_mem_read) ? NEED_MEM_LOAD : NEED_NONE;

    assign o_need  = max_need(w_need_rs, w_need_rt);
    assign o_fwd_a = w_rs_mem && i_mem_reg_write && !i_mem_mem_read;
    assign o_fwd_b = w_rt_mem && i_mem_reg_write && !i_mem_mem_read;

endmodule

// File: rtl/branch_resolve_ctrl.sv
// ID-stage branch controller: stalls on operand hazards, drives the comparator,
// turns its result into PC redirect / IF-ID flush and counts branches.
module branch_resolve_ctrl
    import branch_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5,
    parameter int CNT_W  = 16
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Halt,
    input  logic              IdValid,
    input  logic [2:0]        BranchCtrl,
    input  logic [REG_W-1:0]  IdRs,
    input  logic [REG_W-1:0]  IdRt,
    input  logic [DATA_W-1:0] PcPlus4,
    input  logic [15:0]       Imm16,
    input  logic              ExRegWrite,
    input  logic              ExMemRead,
    input  logic [REG_W-1:0]  ExWriteReg,
    input  logic              MemRegWrite,
    input  logic              MemMemRead,
    input  logic [REG_W-1:0]  MemWriteReg,
    input  logic              CmpResult,
    output logic              CompareFlag,
    output logic [2:0]        CmpControl,
    output logic              FwdA,
    output logic              FwdB,
    output logic              Stall,
    output logic              FlushIfId,
    output logic              PCSrc,
    output logic [DATA_W-1:0] BranchTarget,
    output logic [CNT_W-1:0]  BranchCount,
    output logic [CNT_W-1:0]  TakenCount
);

    localparam logic [CNT_W-1:0] CNT_ONE = 1;

    state_t             r_state, w_state_nxt;
    logic [1:0]         r_cnt, w_cnt_nxt;
    logic [CNT_W-1:0]   r_branch_cnt, r_taken_cnt;
    logic               w_is_br, w_resolve, w_taken;
    logic [1:0]         w_need;
    logic               w_fwd_a, w_fwd_b;
    logic [DATA_W-1:0]  w_offset;

    branch_hazard_detect #(.REG_W(REG_W)) u_hazard (
        .i_rs            (IdRs),
        .i_rt            (IdRt),
        .i_ex_reg_write  (ExRegWrite),
        .i_ex_mem_read   (ExMemRead),
        .i_ex_write_reg  (ExWriteReg),
        .i_mem_reg_write (MemRegWrite),
        .i_mem_mem_read  (MemMemRead),
        .i_mem_write_reg (MemWriteReg),
        .o_need          (w_need),
        .o_fwd_a         (w_fwd_a),
        .o_fwd_b         (w_fwd_b)
    );

    assign w_is_br      = IdValid && ((BranchCtrl == BR_BEQ) || (BranchCtrl == BR_BNE));
    assign w_offset     = {{(DATA_W-18){Imm16[15]}}, Imm16, 2'b00};
    assign BranchTarget = PcPlus4 + w_offset;

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_resolve   = 1'b0;
        w_taken     = 1'b0;
        CompareFlag = 1'b0;
        CmpControl  = BR_NONE;
        FwdA        = 1'b0;
        FwdB        = 1'b0;
        Stall       = 1'b0;
        FlushIfId   = 1'b0;
        PCSrc       = 1'b0;
        // Outputs are forced low while reset is held, even if a hazarded branch sits in ID.
        if (Reset) begin
            w_state_nxt = ST_IDLE;
        end else if (Halt) begin
            Stall = (r_state == ST_STALL);
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_is_br) begin
                        if (w_need != NEED_NONE) begin
                            Stall     = 1'b1;
                            w_cnt_nxt = w_need - 2'd1;
                            if (w_cnt_nxt != 2'd0) w_state_nxt = ST_STALL;
                        end else begin
                            w_resolve   = 1'b1;
                            w_taken     = CmpResult;
                            CompareFlag = 1'b1;
                            CmpControl  = BranchCtrl;
                            FwdA        = w_fwd_a;
                            FwdB        = w_fwd_b;
                            PCSrc       = CmpResult;
                            FlushIfId   = CmpResult;
                        end
                    end
                end
                ST_STALL: begin
                    Stall = 1'b1;
                    if (r_cnt <= 2'd1) begin
                        w_cnt_nxt   = 2'd0;
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_cnt_nxt = r_cnt - 2'd1;
                    end
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state      <= ST_IDLE;
            r_cnt        <= 2'd0;
            r_branch_cnt <= '0;
            r_taken_cnt  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_resolve) r_branch_cnt <= r_branch_cnt + CNT_ONE;
            if (w_taken)   r_taken_cnt  <= r_taken_cnt + CNT_ONE;
        end
    end

    assign BranchCount = r_branch_cnt;
    assign TakenCount  = r_taken_cnt;

endmodule
